// File: rtl/masked_and_redundant_pipe.sv
// masked_and_redundant_pipe
//   Three-stage pipelined 2-share masked AND gadget. Each of WIDTH lanes carries
//   REP replicas of every share. The replicas are majority-voted after the domain
//   products, so a minority of flipped replicas is corrected and the disagreement
//   is flagged and counted.
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   in_valid                   operands valid this cycle
//   port_a_0/1, port_b_0/1     operand shares, bit lane*REP+k = replica k of lane
//   port_r                     fresh mask, one bit per lane shared by all replicas
//   clear_fault                sync clear of fault_sticky / fault_count
//   out_valid                  port_c_* hold one result (3 cycles after in_valid)
//   port_c_0/1                 result shares of a&b, replicated
//   fault_detect               pulse with out_valid: replicas disagreed
//   fault_sticky, fault_count  sticky flag and saturating count of faulty results
module masked_and_redundant_pipe #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REP     = 3,
  parameter int unsigned COUNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH*REP-1:0]     port_a_0,
  input  logic [WIDTH*REP-1:0]     port_a_1,
  input  logic [WIDTH*REP-1:0]     port_b_0,
  input  logic [WIDTH*REP-1:0]     port_b_1,
  input  logic [WIDTH-1:0]         port_r,
  input  logic                     clear_fault,
  output logic                     out_valid,
  output logic [WIDTH*REP-1:0]     port_c_0,
  output logic [WIDTH*REP-1:0]     port_c_1,
  output logic                     fault_detect,
  output logic                     fault_sticky,
  output logic [COUNT_W-1:0]       fault_count
);

  localparam int unsigned N = WIDTH * REP;

  // Per-lane majority of the REP replicas, broadcast back to every replica.
  function automatic logic [N-1:0] vote(input logic [N-1:0] u);
    logic [N-1:0] v;
    int unsigned  ones;
    v = '0;
    for (int unsigned l = 0; l < WIDTH; l++) begin
      ones = 0;
      for (int unsigned k = 0; k < REP; k++) begin
        ones = ones + 32'(u[l*REP+k]);
      end
      v[l*REP +: REP] = {REP{ones > (REP / 2)}};
    end
    return v;
  endfunction

  // Stage registers
  logic [N-1:0] u00_q, u01_q, u10_q, u11_q;
  logic         valid1_q;
  logic [N-1:0] v00_q, v01_q, v10_q, v11_q;
  logic         valid2_q, mis_q;

  logic [N-1:0]       r_rep;
  logic [N-1:0]       v00_d, v01_d, v10_d, v11_d;
  logic               mis_d;
  logic               fault_next;
  logic               sticky_d;
  logic [COUNT_W-1:0] count_d;

  // The single mask bit of a lane feeds all its replicas.
  always_comb begin
    r_rep = '0;
    for (int unsigned l = 0; l < WIDTH; l++) begin
      r_rep[l*REP +: REP] = {REP{port_r[l]}};
    end
  end

  // S1: domain products; cross terms are re-masked before the register so no
  // unmasked combination of shares is ever stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u00_q    <= '0;
      u01_q    <= '0;
      u10_q    <= '0;
      u11_q    <= '0;
      valid1_q <= 1'b0;
    end else begin
      u00_q    <= port_a_0 & port_b_0;
      u11_q    <= port_a_1 & port_b_1;
      u01_q    <= (port_a_0 & port_b_1) ^ r_rep;
      u10_q    <= (port_a_1 & port_b_0) ^ r_rep;
      valid1_q <= in_valid;
    end
  end

  // S2: majority correction and disagreement detection.
  always_comb begin
    v00_d = vote(u00_q);
    v01_d = vote(u01_q);
    v10_d = vote(u10_q);
    v11_d = vote(u11_q);
    mis_d = valid1_q & (|((u00_q ^ v00_d) | (u01_q ^ v01_d) |
                          (u10_q ^ v10_d) | (u11_q ^ v11_d)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v00_q    <= '0;
      v01_q    <= '0;
      v10_q    <= '0;
      v11_q    <= '0;
      valid2_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      v00_q    <= v00_d;
      v01_q    <= v01_d;
      v10_q    <= v10_d;
      v11_q    <= v11_d;
      valid2_q <= valid1_q;
      mis_q    <= mis_d;
    end
  end

  // S3 fault accounting: a clear takes effect before a coincident fault.
  always_comb begin
    fault_next = valid2_q & mis_q;
    sticky_d   = (fault_sticky & ~clear_fault) | fault_next;
    count_d    = clear_fault ? '0 : fault_count;
    if (fault_next && (count_d != {COUNT_W{1'b1}})) begin
      count_d = count_d + 1'b1;
    end
  end

  // S3: compression and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_c_0     <= '0;
      port_c_1     <= '0;
      out_valid    <= 1'b0;
      fault_detect <= 1'b0;
      fault_sticky <= 1'b0;
      fault_count  <= '0;
    end else begin
      port_c_0     <= v00_q ^ v01_q;
      port_c_1     <= v10_q ^ v11_q;
      out_valid    <= valid2_q;
      fault_detect <= fault_next;
      fault_sticky <= sticky_d;
      fault_count  <= count_d;
    end
  end

endmodule
